pulpemu_rst_ctrl: RTL

PULPEMU_RST_CTRL -- requirements
Module: pulpemu_rst_ctrl

---
 rtl/pulpemu_rst_ctrl.sv | 133 +++++++++++++
 1 files changed

// File: rtl/pulpemu_rst_ctrl.sv
// Board-level reset controller for the PULP emulator. It synchronizes the button, JTAG TRST and
// clock-lock inputs, debounces the button, and stretches the SoC reset to a minimum width.
module pulpemu_rst_ctrl #(
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = 1000,
  parameter int HOLD_CYCLES     = 256
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       btn_rst_i,
  input  logic       jtag_trst_ni,
  input  logic       clk_locked_i,
  output logic       soc_rst_no,
  output logic       rst_active_o,
  output logic [1:0] rst_cause_o,
  output logic [7:0] rst_count_o
);

  localparam int DB_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam int HC_W = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
  localparam logic [DB_W-1:0] DB_LAST = DB_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [HC_W-1:0] HC_LAST = HC_W'(HOLD_CYCLES - 1);

  typedef enum logic {HOLD = 1'b0, RUN = 1'b1} state_e;

  logic [SYNC_STAGES-1:0] btn_sync_q, trst_sync_q, lock_sync_q;
  logic                   btn_sync, trst_sync, lock_sync;

  logic [DB_W-1:0] db_cnt_q, db_cnt_d;
  logic            btn_db_q, btn_db_d;

  state_e          state_q;
  logic [HC_W-1:0] hold_cnt_q;
  logic            soc_rst_nq;
  logic            rst_active_q;
  logic [1:0]      rst_cause_q, rst_cause_d;
  logic [7:0]      rst_count_q, rst_count_d;
  logic            req;

  // Reset values make every chain request reset until real input levels have propagated.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      btn_sync_q  <= '1;
      trst_sync_q <= '0;
      lock_sync_q <= '0;
    end else begin
      btn_sync_q  <= {btn_sync_q[SYNC_STAGES-2:0], btn_rst_i};
      trst_sync_q <= {trst_sync_q[SYNC_STAGES-2:0], jtag_trst_ni};
      lock_sync_q <= {lock_sync_q[SYNC_STAGES-2:0], clk_locked_i};
    end
  end

  assign btn_sync  = btn_sync_q[SYNC_STAGES-1];
  assign trst_sync = trst_sync_q[SYNC_STAGES-1];
  assign lock_sync = lock_sync_q[SYNC_STAGES-1];

  always_comb begin
    db_cnt_d = '0;
    btn_db_d = btn_db_q;
    if (btn_sync != btn_db_q) begin
      if (db_cnt_q == DB_LAST) btn_db_d = btn_sync;
      else                     db_cnt_d = db_cnt_q + DB_W'(1);
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      db_cnt_q <= '0;
      btn_db_q <= 1'b1;
    end else begin
      db_cnt_q <= db_cnt_d;
      btn_db_q <= btn_db_d;
    end
  end

  assign req = btn_db_q | ~trst_sync | ~lock_sync;

  // Lock loss outranks JTAG, which outranks the button, when several sources fire together.
  always_comb begin
    rst_cause_d = 2'b01;
    if (!lock_sync)      rst_cause_d = 2'b11;
    else if (!trst_sync) rst_cause_d = 2'b10;
    rst_count_d = (rst_count_q == 8'hFF) ? rst_count_q : rst_count_q + 8'd1;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q      <= HOLD;
      hold_cnt_q   <= '0;
      soc_rst_nq   <= 1'b0;
      rst_active_q <= 1'b1;
      rst_cause_q  <= 2'b00;
      rst_count_q  <= 8'd0;
    end else begin
      case (state_q)
        HOLD: begin
          if (req) begin
            hold_cnt_q <= '0;
          end else if (hold_cnt_q == HC_LAST) begin
            state_q      <= RUN;
            hold_cnt_q   <= '0;
            soc_rst_nq   <= 1'b1;
            rst_active_q <= 1'b0;
          end else begin
            hold_cnt_q <= hold_cnt_q + HC_W'(1);
          end
        end
        RUN: begin
          if (req) begin
            state_q      <= HOLD;
            hold_cnt_q   <= '0;
            soc_rst_nq   <= 1'b0;
            rst_active_q <= 1'b1;
            rst_cause_q  <= rst_cause_d;
            rst_count_q  <= rst_count_d;
          end
        end
        default: begin
          state_q      <= HOLD;
          hold_cnt_q   <= '0;
          soc_rst_nq   <= 1'b0;
          rst_active_q <= 1'b1;
        end
      endcase
    end
  end

  assign soc_rst_no   = soc_rst_nq;
  assign rst_active_o = rst_active_q;
  assign rst_cause_o  = rst_cause_q;
  assign rst_count_o  = rst_count_q;

endmodule
